vram_port_arbiter: RTL and testbench
====================================

# vram_port_arbiter

Shares the single physical port of the text-mode VRAM block RAM between two requesters. The pixel fetch path reads one 32-bit word (four glyph codes) per request. The CPU/AXI register path reads and writes words with byte enables. Display fetches normally win, a bounded-starvation rule guarantees CPU progress, and read data returns with the BRAM's fixed one-cycle latency, tagged to its owner.

## Interface
Parameters:
- ADDR_W, default 10, VRAM word address width (80x30 glyphs / 4 per word = 600 words).
- DATA_W, default 32, VRAM word width; byte-enable width is DATA_W/8.
- STARVE_MAX, default 4, number of consecutive cycles the CPU may be denied before a forced CPU grant.

Ports:
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  asynchronous, active-low reset.
- vblank  in  1  high during vertical blanking; the CPU takes priority while high.
- disp_req  in  1  display read request; holds with its address until granted.
- disp_addr  in  ADDR_W  display word address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  disp_rdata valid (one-cycle pulse).
- disp_rdata  out  DATA_W  display read word.
- disp_late  out  1  registered pulse: the display was denied in the previous cycle.
- cpu_req  in  1  CPU access request; holds with all fields until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_be  in  DATA_W/8  write byte enables.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  CPU request accepted this cycle; for writes, the write commits at this edge.
- cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse, reads only).
- cpu_rdata  out  DATA_W  CPU read word.
- bram_en  out  1  BRAM port enable.
- bram_we  out  DATA_W/8  BRAM byte write enables.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wdata  out  DATA_W  BRAM write data.
- bram_rdata  in  DATA_W  BRAM read data, valid one cycle after the enabled read.

## Operation
- At most one grant per cycle. The grant decision and the bram_* outputs are combinational from the current requests, the vblank input and the internal state.
- Priority order:
  - The CPU wins if force_cpu (starve_cnt == STARVE_MAX) or vblank = 1.
  - Otherwise the display wins.
  - The sole requester always wins.
- starve_cnt has width clog2(STARVE_MAX+1):
  - Increments when cpu_req = 1 and cpu_gnt = 0.
  - Clears to 0 on cpu_gnt, or when cpu_req = 0.
  - Saturates at STARVE_MAX.
- Granted display: bram_en = 1, bram_we = 0, bram_addr = disp_addr.
- Granted CPU: bram_en = 1, bram_addr = cpu_addr, bram_wdata = cpu_wdata, bram_we = cpu_we ? cpu_be : 0.
  - A write with cpu_be = 0 is still granted and consumes the slot.
- No grant: bram_en = 0, bram_we = 0, and addr/wdata are don't-care (driven 0).
- Owner tag register (NONE / DISP / CPU_RD):
  - Loaded every cycle with the current grant type.
  - CPU writes load NONE.
- Return routing, one cycle after a grant:
  - Tag DISP: disp_rvalid = 1, disp_rdata = bram_rdata.
  - Tag CPU_RD: cpu_rvalid = 1, cpu_rdata = bram_rdata.
  - Each rdata output holds its last value when its rvalid is low.
- disp_late is registered high for one cycle after any cycle where disp_req = 1 and disp_gnt = 0.

## Timing
- Reset (axi_aresetn low):
  - Asynchronous effect: tag = NONE, starve_cnt = 0, all rvalid = 0, disp_late = 0, both rdata = 0.
  - Grants and bram_en/bram_we are forced 0 for as long as reset is asserted.
- Grant latency: 0 cycles (same cycle as the request) when uncontested.
- Read latency: rvalid and rdata arrive exactly 1 cycle after gnt.
- Throughput: back-to-back grants are allowed every cycle, including alternating owners; the tag pipeline carries one entry per cycle.
- Worst-case CPU wait under continuous display requests: STARVE_MAX denied cycles, then a grant on the next cycle.
- The display loses at most 1 slot per STARVE_MAX+1 cycles outside vblank.
- Reset mid-read: the pending tag is discarded and no rvalid is issued after release.
- A requester may drop req without a grant. No state other than starve_cnt clearing results.

## Test plan
- Reset: hold axi_aresetn low with both reqs high -> gnts = 0, bram_en = 0, rvalids = 0. Release -> the display is granted in the first cycle.
- Display read: disp_req at addr 0x12B, BRAM preloaded with 0xDEADBEEF -> disp_gnt in cycle T; disp_rvalid = 1 with disp_rdata = 0xDEADBEEF at T+1; cpu_rvalid = 0.
- Starvation: disp_req held high, cpu_req read at addr 5, STARVE_MAX = 4 -> cpu_gnt in cycle 5, disp_late pulses once after that cycle, cpu_rvalid in cycle 6, starve_cnt = 0 afterwards.
- Vblank: vblank = 1 with both requesting -> cpu_gnt immediately; CPU write addr 7, be = 4'b0011, wdata 0xAABBCCDD over 0x11223344 -> a later read returns 0x1122CCDD and no cpu_rvalid is pulsed for the write.
- Alternating: display and CPU reads interleaved each cycle via vblank toggling -> every rvalid is routed to the correct owner with the correct data, and no cycle has both rvalids high.
- Reset mid-read: assert axi_aresetn one cycle after a CPU read grant -> no cpu_rvalid pulse, and cpu_rdata = 0 after reset.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter for the single text-mode VRAM BRAM port: display reads
// normally win, CPU wins in vblank or after bounded starvation; read data tagged to owner.
module vram_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  vblank,
    input  logic                  disp_req,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic                  disp_gnt,
    output logic                  disp_rvalid,
    output logic [DATA_W-1:0]     disp_rdata,
    output logic                  disp_late,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_W/8-1:0]   cpu_be,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  bram_en,
    output logic [DATA_W/8-1:0]   bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]     bram_wdata,
    input  logic [DATA_W-1:0]     bram_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        TAG_NONE   = 2'b00,
        TAG_DISP   = 2'b01,
        TAG_CPU_RD = 2'b10
    } tag_t;

    tag_t              tag_r;
    tag_t              tag_next_s;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic              force_cpu_s;
    logic              cpu_win_s;
    logic              disp_win_s;
    logic              disp_late_r;
    logic [DATA_W-1:0] disp_rdata_r;
    logic [DATA_W-1:0] cpu_rdata_r;

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        force_cpu_s = (starve_cnt_r == CNT_MAX);
        cpu_win_s   = 1'b0;
        disp_win_s  = 1'b0;
        if (!axi_aresetn) begin
            cpu_win_s  = 1'b0;
            disp_win_s = 1'b0;
        end else if (cpu_req && (!disp_req || force_cpu_s || vblank)) begin
            cpu_win_s = 1'b1;
        end else if (disp_req) begin
            disp_win_s = 1'b1;
        end else begin
            cpu_win_s  = 1'b0;
            disp_win_s = 1'b0;
        end
    end

    // BRAM port drive and owner tag for the access issued this cycle
    always_comb begin
        bram_en    = 1'b0;
        bram_we    = {BE_W{1'b0}};
        bram_addr  = {ADDR_W{1'b0}};
        bram_wdata = {DATA_W{1'b0}};
        tag_next_s = TAG_NONE;
        if (cpu_win_s) begin
            bram_en    = 1'b1;
            bram_addr  = cpu_addr;
            bram_wdata = cpu_wdata;
            bram_we    = cpu_we ? cpu_be : {BE_W{1'b0}};
            tag_next_s = cpu_we ? TAG_NONE : TAG_CPU_RD;
        end else if (disp_win_s) begin
            bram_en    = 1'b1;
            bram_addr  = disp_addr;
            tag_next_s = TAG_DISP;
        end else begin
            tag_next_s = TAG_NONE;
        end
    end

    assign disp_gnt = disp_win_s;
    assign cpu_gnt  = cpu_win_s;

    // Owner tag pipeline, one entry per cycle
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            tag_r <= TAG_NONE;
        end else begin
            tag_r <= tag_next_s;
        end
    end

    // Starvation counter: counts consecutive CPU denials, saturating
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (cpu_req && !cpu_win_s) begin
            if (starve_cnt_r != CNT_MAX) begin
                starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Late flag: the display asked and was refused last cycle
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            disp_late_r <= 1'b0;
        end else begin
            disp_late_r <= disp_req && !disp_win_s;
        end
    end

    // Read data hold registers, refreshed on each returned word
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            disp_rdata_r <= {DATA_W{1'b0}};
            cpu_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            if (tag_r == TAG_DISP) begin
                disp_rdata_r <= bram_rdata;
            end else begin
                disp_rdata_r <= disp_rdata_r;
            end
            if (tag_r == TAG_CPU_RD) begin
                cpu_rdata_r <= bram_rdata;
            end else begin
                cpu_rdata_r <= cpu_rdata_r;
            end
        end
    end

    // BRAM data is only valid in the return cycle, so it bypasses the hold register
    assign disp_rvalid = (tag_r == TAG_DISP);
    assign cpu_rvalid  = (tag_r == TAG_CPU_RD);
    assign disp_rdata  = disp_rvalid ? bram_rdata : disp_rdata_r;
    assign cpu_rdata   = cpu_rvalid ? bram_rdata : cpu_rdata_r;
    assign disp_late   = disp_late_r;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: behavioural BRAM, reference memory and a
// scoreboard queue of expected returned words per cycle.
module tb_vram_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vblank;
    logic        disp_req;
    logic [9:0]  disp_addr;
    logic        disp_gnt;
    logic        disp_rvalid;
    logic [31:0] disp_rdata;
    logic        disp_late;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;

    vram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n), .vblank(vblank),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata), .disp_late(disp_late),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port BRAM, one-cycle read latency
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            end
            bram_rdata <= mem[bram_addr];
        end
    end

    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} own_t;
    typedef struct {
        own_t        owner;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic       d, c, we, vb;
        logic [9:0] da, ca;
        logic       edg, ecg;
    } vec_t;

    sb_t         sb_q[$];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] disp_hold, cpu_hold;
    logic        late_exp;
    int          n_total = 0;
    int          n_pass  = 0;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic sb_reset();
        sb_t e;
        sb_q.delete();
        e.owner = OWN_NONE;
        e.data  = 32'h0;
        sb_q.push_back(e);
        disp_hold = 32'h0;
        cpu_hold  = 32'h0;
        late_exp  = 1'b0;
    endtask

    // One clock cycle: drive, check grant/port and returned data, predict next return
    task automatic cyc(input logic d, input logic c, input logic we, input logic vb,
                       input logic [9:0] da, input logic [9:0] ca, input logic [3:0] be,
                       input logic [31:0] wd, input logic edg, input logic ecg);
        sb_t e;
        sb_t n;
        logic [9:0] exp_addr;
        disp_req = d; cpu_req = c; cpu_we = we; vblank = vb;
        disp_addr = da; cpu_addr = ca; cpu_be = be; cpu_wdata = wd;
        @(negedge clk);
        exp_addr = ecg ? ca : (edg ? da : 10'h0);
        chk("disp_gnt", {31'h0, disp_gnt}, {31'h0, edg});
        chk("cpu_gnt", {31'h0, cpu_gnt}, {31'h0, ecg});
        chk("bram_en", {31'h0, bram_en}, {31'h0, edg | ecg});
        chk("bram_we", {28'h0, bram_we}, {28'h0, (ecg && we) ? be : 4'h0});
        chk("bram_addr", {22'h0, bram_addr}, {22'h0, exp_addr});
        chk("disp_late", {31'h0, disp_late}, {31'h0, late_exp});
        late_exp = d && !edg;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            if (e.owner == OWN_DISP) disp_hold = e.data;
            if (e.owner == OWN_CPU)  cpu_hold  = e.data;
            chk("disp_rvalid", {31'h0, disp_rvalid}, {31'h0, e.owner == OWN_DISP});
            chk("cpu_rvalid", {31'h0, cpu_rvalid}, {31'h0, e.owner == OWN_CPU});
            chk("disp_rdata", disp_rdata, disp_hold);
            chk("cpu_rdata", cpu_rdata, cpu_hold);
            chk("rvalid_excl", {31'h0, disp_rvalid & cpu_rvalid}, 32'h0);
        end
        n.owner = OWN_NONE;
        n.data  = 32'h0;
        if (edg) begin
            n.owner = OWN_DISP;
            n.data  = ref_mem[da];
        end else if (ecg && !we) begin
            n.owner = OWN_CPU;
            n.data  = ref_mem[ca];
        end else if (ecg && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[ca][8*b +: 8] = wd[8*b +: 8];
            end
        end
        sb_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic d, input logic c, input logic vb,
                      input logic [9:0] da, input logic [9:0] ca,
                      input logic edg, input logic ecg);
        cyc(d, c, 1'b0, vb, da, ca, 4'h0, 32'h0, edg, ecg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'h5A000000 ^ (i * 32'h00010203);
            ref_mem[i] = 32'h5A000000 ^ (i * 32'h00010203);
        end
        mem[10'h12B] = 32'hDEADBEEF; ref_mem[10'h12B] = 32'hDEADBEEF;
        mem[7]       = 32'h11223344; ref_mem[7]       = 32'h11223344;

        // {d, c, we, vb, da, ca, exp disp_gnt, exp cpu_gnt}
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h040, 10'h080, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h041, 10'h081, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h042, 10'h082, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h043, 10'h083, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h044, 10'h084, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h045, 10'h085, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h046, 10'h086, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h047, 10'h087, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h048, 10'h088, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h049, 10'h089, 1'b0, 1'b0};

        rst_n = 1'b0; vblank = 1'b0; disp_req = 1'b1; cpu_req = 1'b1;
        cpu_we = 1'b0; cpu_be = 4'h0; disp_addr = 10'h12B; cpu_addr = 10'h5;
        cpu_wdata = 32'h0;
        sb_reset();

        // Reset held with both requesting
        repeat (2) begin
            @(negedge clk);
            chk("rst_disp_gnt", {31'h0, disp_gnt}, 32'h0);
            chk("rst_cpu_gnt", {31'h0, cpu_gnt}, 32'h0);
            chk("rst_bram_en", {31'h0, bram_en}, 32'h0);
            chk("rst_bram_we", {28'h0, bram_we}, 32'h0);
            chk("rst_rvalids", {30'h0, disp_rvalid, cpu_rvalid}, 32'h0);
            chk("rst_late", {31'h0, disp_late}, 32'h0);
            chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First cycle after release: display wins; then its word returns
        rd(1'b1, 1'b1, 1'b0, 10'h12B, 10'h005, 1'b1, 1'b0);
        rd(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("disp_deadbeef", disp_rdata, 32'hDEADBEEF);

        // Priority table
        for (int i = 0; i < 10; i++) begin
            rd(vecs[i].d, vecs[i].c, vecs[i].vb, vecs[i].da, vecs[i].ca,
               vecs[i].edg, vecs[i].ecg);
        end

        // Starvation: SM denials, then forced CPU grant
        for (int i = 0; i <= SM; i++) begin
            rd(1'b1, 1'b1, 1'b0, 10'(20 + i), 10'h005, i < SM, i == SM);
        end
        rd(1'b1, 1'b0, 1'b0, 10'h030, 10'h005, 1'b1, 1'b0);
        // Dropping the request after partial starvation restarts the count
        for (int i = 0; i < SM - 1; i++) begin
            rd(1'b1, 1'b1, 1'b0, 10'(40 + i), 10'h006, 1'b1, 1'b0);
        end
        rd(1'b1, 1'b0, 1'b0, 10'h031, 10'h006, 1'b1, 1'b0);
        for (int i = 0; i <= SM; i++) begin
            rd(1'b1, 1'b1, 1'b0, 10'(60 + i), 10'h006, i < SM, i == SM);
        end
        rd(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);

        // Vblank partial write, zero-enable write, then read-back
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 10'h050, 10'h007, 4'b0011, 32'hAABBCCDD, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 10'h050, 10'h007, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b1);
        rd(1'b0, 1'b1, 1'b0, 10'h050, 10'h007, 1'b0, 1'b1);
        rd(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        chk("write_merge", cpu_rdata, 32'h1122CCDD);

        // Alternating owners via vblank toggling
        for (int i = 0; i < 8; i++) begin
            rd(1'b1, 1'b1, i[0], 10'(100 + i), 10'(200 + i), !i[0], i[0]);
        end
        rd(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);

        // Reset one cycle after a CPU read grant
        rd(1'b0, 1'b1, 1'b0, 10'h000, 10'h009, 1'b0, 1'b1);
        rst_n = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
        chk("mid_rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("mid_rst_disp_rdata", disp_rdata, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_reset();
        rd(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);
        rd(1'b1, 1'b0, 1'b0, 10'h12B, 10'h000, 1'b1, 1'b0);
        rd(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
